// File: rtl/pixel_stream_framer.sv
// pixel_stream_framer
// ---------------------------------------------------------------------------
// Frames a raw pixel stream into H_ACTIVE x V_ACTIVE frames. Each accepted
// pixel is re-issued one cycle later together with its (x, y) position and
// first-of-frame / last-of-line / last-of-frame markers. Framing problems
// (a frame_start_in arriving mid-frame, or pixels arriving after a frame has
// completed but before the next frame_start_in) raise a sticky error flag.
//
// Stream semantics: valid-only strobe, no backpressure. A pixel is transferred
// in every cycle where pixel_valid_in=1; the output side likewise presents one
// pixel per cycle where pixel_valid_out=1, and markers are only meaningful
// (and are forced to 0 otherwise) while pixel_valid_out=1.
//
// Optional feature: define FRAMER_ERR_CNT_EN to enable the 16-bit saturating
// error-event counter on err_count; without it err_count is tied to 0.
//
// Ports
//   clk              sole clock, rising edge
//   rst_n            asynchronous active-low reset
//   frame_start_in   one-cycle pulse, start of a new frame
//   pixel_valid_in   rgb_in holds an active pixel this cycle
//   rgb_in[23:0]     pixel {R,G,B}
//   err_clr          clears frame_err / err_count (an error event wins)
//   pixel_valid_out  registered pixel strobe
//   rgb_out[23:0]    registered pixel
//   x_out, y_out     column / row of the output pixel
//   sof_out          first pixel of frame
//   eol_out          last pixel of line
//   eof_out          last pixel of frame
//   frame_err        sticky framing-error flag
//   err_count[15:0]  framing-error event counter
//   state_dbg        FSM state, 0 = WAIT_SOF, 1 = ACTIVE
// ---------------------------------------------------------------------------
module pixel_stream_framer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start_in,
  input  logic                        pixel_valid_in,
  input  logic [23:0]                 rgb_in,
  input  logic                        err_clr,
  output logic                        pixel_valid_out,
  output logic [23:0]                 rgb_out,
  output logic [$clog2(H_ACTIVE)-1:0] x_out,
  output logic [$clog2(V_ACTIVE)-1:0] y_out,
  output logic                        sof_out,
  output logic                        eol_out,
  output logic                        eof_out,
  output logic                        frame_err,
  output logic [15:0]                 err_count,
  output logic                        state_dbg
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [XW-1:0] x_cnt, x_cnt_next, cur_x;
  logic [YW-1:0] y_cnt, y_cnt_next, cur_y;
  logic          frame_done, frame_done_next;
  logic          accept;
  logic          at_eol, at_eof;
  logic          short_err, overrun_err, err_event;

  assign state_dbg = (state == ACTIVE);

  // -------------------------------------------------------------------------
  // Next-state / position logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    x_cnt_next      = x_cnt;
    y_cnt_next      = y_cnt;
    frame_done_next = frame_done;
    cur_x           = x_cnt;
    cur_y           = y_cnt;
    accept          = 1'b0;
    at_eol          = 1'b0;
    at_eof          = 1'b0;
    short_err       = 1'b0;
    overrun_err     = 1'b0;

    // A frame start re-bases the position in the same cycle, so a pixel that
    // arrives together with the pulse lands on (0,0) of the new frame.
    if (frame_start_in) begin
      cur_x = '0;
      cur_y = '0;
    end

    accept = pixel_valid_in && (frame_start_in || (state == ACTIVE));
    at_eol = accept && (cur_x == X_LAST);
    at_eof = at_eol && (cur_y == Y_LAST);

    // Any frame start while a frame is still open truncates that frame.
    short_err = frame_start_in && (state == ACTIVE);
    // Stray pixels only count as an overrun once a frame has completed;
    // pixels seen before the very first frame start are simply ignored.
    overrun_err = pixel_valid_in && !frame_start_in &&
                  (state == WAIT_SOF) && frame_done;

    x_cnt_next = cur_x;
    y_cnt_next = cur_y;
    if (accept) begin
      if (at_eol) begin
        x_cnt_next = '0;
        y_cnt_next = at_eof ? '0 : cur_y + 1'b1;
      end else begin
        x_cnt_next = cur_x + 1'b1;
      end
    end

    if (frame_start_in) begin
      state_next      = ACTIVE;
      frame_done_next = 1'b0;
    end
    if (at_eof) begin
      state_next      = WAIT_SOF;
      frame_done_next = 1'b1;
    end
  end

  assign err_event = short_err || overrun_err;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_SOF;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Position counters and frame-completed tracker
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      frame_done <= 1'b0;
    end else begin
      x_cnt      <= x_cnt_next;
      y_cnt      <= y_cnt_next;
      frame_done <= frame_done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output pixel register: data/position hold across gaps, markers do not.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid_out <= 1'b0;
      rgb_out         <= '0;
      x_out           <= '0;
      y_out           <= '0;
      sof_out         <= 1'b0;
      eol_out         <= 1'b0;
      eof_out         <= 1'b0;
    end else begin
      pixel_valid_out <= accept;
      sof_out         <= accept && (cur_x == '0) && (cur_y == '0);
      eol_out         <= at_eol;
      eof_out         <= at_eof;
      if (accept) begin
        rgb_out <= rgb_in;
        x_out   <= cur_x;
        y_out   <= cur_y;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flag: a new event takes priority over a clear.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (err_event) begin
      frame_err <= 1'b1;
    end else if (err_clr) begin
      frame_err <= 1'b0;
    end
  end

`ifdef FRAMER_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Event together with clear restarts the count at one, so the event that
  // kept frame_err set is still accounted for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_event) begin
      if (err_clr) begin
        err_cnt_q <= 16'd1;
      end else if (err_cnt_q != 16'hFFFF) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: doc/pixel_stream_framer.md
PIXEL_STREAM_FRAMER -- requirements
Module: pixel_stream_framer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port frame_start_in  input  1  single-cycle pulse marking the start of a new frame.
REQ-006 SHALL have port pixel_valid_in  input  1  rgb_in carries an active pixel this cycle.
REQ-007 SHALL have port rgb_in  input  24  pixel, {R,G,B}.
REQ-008 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-009 SHALL have port pixel_valid_out  output  1  registered pixel strobe feeding the enhancement pipeline.
REQ-010 SHALL have port rgb_out  output  24  registered pixel.
REQ-011 SHALL have port x_out  output  $clog2(H_ACTIVE)  column of the output pixel.
REQ-012 SHALL have port y_out  output  $clog2(V_ACTIVE)  row of the output pixel.
REQ-013 SHALL have ports sof_out, eol_out, eof_out  output  1 each  first-of-frame, last-of-line and last-of-frame markers, qualified by pixel_valid_out.
REQ-014 SHALL have port frame_err  output  1  sticky framing-error flag.
REQ-015 SHALL have port err_count  output  16  framing-error event counter.

Function
REQ-016 SHALL implement FSM states WAIT_SOF and ACTIVE.
REQ-017 SHALL, in WAIT_SOF, discard pixel_valid_in pixels, so that pixel_valid_out=0.
REQ-018 SHALL, on frame_start_in, reset x/y to 0 and enter ACTIVE.
REQ-019 SHALL, when frame_start_in and pixel_valid_in occur in the same cycle, treat that pixel as (0,0) of the new frame, with sof_out=1.
REQ-020 SHALL, in ACTIVE, register each valid pixel with 1-cycle latency: rgb_out, x_out and y_out equal the input-cycle values.
REQ-021 SHALL, at x=H_ACTIVE-1, assert eol_out, wrap x to 0 and increment y.
REQ-022 SHALL, at x=H_ACTIVE-1 and y=V_ACTIVE-1, assert eof_out with eol_out and return to WAIT_SOF.
REQ-023 SHALL hold rgb_out, x_out and y_out when pixel_valid_in=0 (gaps allowed), and keep markers 0.
REQ-024 SHALL, on frame_start_in while ACTIVE and not at frame end (short frame), set frame_err, count one event and restart at (0,0).
REQ-025 SHALL, on pixel_valid_in in WAIT_SOF after a completed frame (overrun), set frame_err, count one event and drop the pixel.
REQ-026 SHALL clear frame_err and err_count on err_clr; set SHALL win over a simultaneous clear.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force FSM=WAIT_SOF, all outputs 0 and counters 0.
REQ-028 SHALL, on reset mid-frame, discard the partial frame and require a new frame_start_in.

Configuration
REQ-029 SHALL, when macro FRAMER_ERR_CNT_EN is defined, make err_count a 16-bit saturating counter (holds 16'hFFFF).
REQ-030 SHALL, when FRAMER_ERR_CNT_EN is undefined, tie err_count to 0 and leave frame_err behaviour unchanged.

Verification (H_ACTIVE=4, V_ACTIVE=2)
REQ-031 SHALL verify frame_start_in, then 8 contiguous pixels 0x000001..0x000008 -> same data 1 cycle later; sof on the 1st pixel, eol on the 4th and 8th, eof on the 8th; FSM ends in WAIT_SOF.
REQ-032 SHALL verify 3 pixels with no frame_start_in -> pixel_valid_out stays 0 and frame_err stays 0.
REQ-033 SHALL verify frame_start_in, 5 pixels, frame_start_in again -> frame_err=1, err_count=1 (0 without macro), next pixel at x=0,y=0 with sof=1.
REQ-034 SHALL verify a full frame, then an extra pixel -> pixel dropped and frame_err=1; err_clr and error in the same cycle -> frame_err stays 1.
REQ-035 SHALL verify frame_start_in with pixel 0xABCDEF in the same cycle -> rgb_out=0xABCDEF, x=0, y=0, sof=1.
REQ-036 SHALL verify rst_n pulsed low after pixel 6 -> all outputs 0 immediately; following pixels dropped until frame_start_in.
